// File: rtl/mod_step_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_step_counter_pkg
//   Shared definitions for the step counter:
//     state_t   : control FSM encoding (IDLE / COUNT / HOLD)
//     MODE_*    : overflow handling mode as captured on init
//     DIR_*     : count direction fed to the add/sub datapath
// ---------------------------------------------------------------------------
package mod_step_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/mod_addsub.sv
// ---------------------------------------------------------------------------
// mod_addsub
//   Combinational modular step adder/subtractor for the step counter.
//   Works one bit wider than the counter so out+step never aliases.
//   Ports:
//     out     in   WIDTH   current count value
//     step    in   STEP_W  unsigned step magnitude
//     limit_q in   WIDTH   captured terminal value (modulus M = limit_q+1)
//     dir     in   1       DIR_UP / DIR_DN
//     nxt     out  WIDTH   wrapped next value (valid for wrap mode)
//     ovf     out  1       move would cross limit_q (up) or 0 (down)
// ---------------------------------------------------------------------------
module mod_addsub
  import mod_step_counter_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]  out,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit_q,
  input  logic              dir,
  output logic [WIDTH-1:0]  nxt,
  output logic              ovf
);

  localparam int XW = WIDTH + 1;

  logic [XW-1:0] out_x;
  logic [XW-1:0] step_x;
  logic [XW-1:0] lim_x;
  logic [XW-1:0] mod_x;
  logic [XW-1:0] sum_x;

  assign out_x  = {1'b0, out};
  assign step_x = XW'(step);
  assign lim_x  = {1'b0, limit_q};
  assign mod_x  = lim_x + XW'(1);
  assign sum_x  = out_x + step_x;

  // Only a single reduction by M is applied; steps larger than M are
  // outside the legal range and simply truncate.
  always_comb begin
    nxt = out;
    ovf = 1'b0;
    if (dir == DIR_UP) begin
      ovf = (sum_x > lim_x);
      nxt = ovf ? WIDTH'(sum_x - mod_x) : WIDTH'(sum_x);
    end else begin
      ovf = (out_x < step_x);
      nxt = ovf ? WIDTH'(out_x + mod_x - step_x) : WIDTH'(out_x - step_x);
    end
  end

endmodule

// File: rtl/mod_step_counter.sv
// ---------------------------------------------------------------------------
// mod_step_counter
//   Up/down counter moving by a programmable step inside [0..limit],
//   with wrap or saturate handling and an IDLE/COUNT/HOLD control FSM.
//   Ports:
//     clk       in   1       rising-edge clock
//     rst_n     in   1       asynchronous active-low reset
//     clr       in   1       synchronous clear (out=0, FSM->IDLE)
//     init      in   1       load PI, capture limit/sat_mode, FSM->COUNT
//     PI        in   WIDTH   load value (clamped to limit)
//     limit     in   WIDTH   terminal value, sampled on init
//     sat_mode  in   1       sampled on init: 1 = saturate, 0 = wrap
//     inc/dec   in   1       count up / down by step
//     step      in   STEP_W  step magnitude
//     out       out  WIDTH   registered count
//     co        out  1       out == captured limit (combinational)
//     wrap      out  1       one-cycle pulse on modular wrap
//     busy      out  1       FSM in COUNT
//     done      out  1       FSM in HOLD
// ---------------------------------------------------------------------------
module mod_step_counter
  import mod_step_counter_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              init,
  input  logic [WIDTH-1:0]  PI,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  out,
  output logic              co,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             sat_q;
  logic [WIDTH-1:0] nxt;
  logic             ovf;
  logic             move;

  // A move needs exactly one direction and a non-zero step.
  assign move = (inc ^ dec) && (step != '0);

  mod_addsub #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_addsub (
    .out     (out),
    .step    (step),
    .limit_q (limit_q),
    .dir     (dec ? DIR_DN : DIR_UP),
    .nxt     (nxt),
    .ovf     (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out     <= '0;
      limit_q <= '1;
      sat_q   <= MODE_WRAP;
      wrap    <= 1'b0;
      state   <= ST_IDLE;
    end else if (clr) begin
      out   <= '0;
      wrap  <= 1'b0;
      state <= ST_IDLE;
    end else if (init) begin
      out     <= (PI > limit) ? limit : PI;
      limit_q <= limit;
      sat_q   <= sat_mode;
      wrap    <= 1'b0;
      state   <= ST_COUNT;
    end else begin
      wrap <= 1'b0;
      if (state == ST_COUNT && move) begin
        if (!ovf) begin
          out <= nxt;
        end else if (sat_q == MODE_WRAP) begin
          out  <= nxt;
          wrap <= 1'b1;
        end else begin
          // Saturate at the bound crossed and park in HOLD.
          out   <= dec ? '0 : limit_q;
          state <= ST_HOLD;
        end
      end
    end
  end

  assign co   = (out == limit_q);
  assign busy = (state == ST_COUNT);
  assign done = (state == ST_HOLD);

endmodule
